mem_arbiter: RTL and testbench

- Shares the single main-memory port between the instruction-cache refill path and the data-cache miss/write-through path.
- Models the fixed main-memory latency with a countdown.
- Streams refill lines one word per cycle back to the requesting cache.
- Pulses a per-side done flag that the caches use to release the pipeline stall the hazard logic holds during a miss.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_lat_counter.sv | 17 +
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding, owner encoding and default sizing for mem_arbiter
package mem_arb_pkg;
  localparam int DEF_MEM_LAT = 5;
  localparam int DEF_LINE_WORDS = 4;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t WAIT = 3'd1;
  localparam state_t XFER = 3'd2;
  localparam state_t WRITE = 3'd3;
  localparam state_t DONE = 3'd4;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag for the memory latency wait
module mem_lat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? load_val : dec ? count - 1'b1 : count;
  assign zero = count == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I-cache refills and D-cache fills/write-throughs
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          CLK,
  input  logic                          CLR,
  input  logic                          IReq,
  input  logic [ADDR_W-1:0]             IAddr,
  input  logic                          DReq,
  input  logic                          DWrite,
  input  logic [ADDR_W-1:0]             DAddr,
  input  logic [DATA_W-1:0]             DWData,
  output logic [ADDR_W-1:0]             MemAddr,
  output logic                          MemWE,
  output logic [DATA_W-1:0]             MemWData,
  input  logic [DATA_W-1:0]             MemRData,
  output logic                          FillValid,
  output logic                          FillToD,
  output logic [$clog2(LINE_WORDS)-1:0] FillWord,
  output logic [DATA_W-1:0]             FillData,
  output logic                          IDone,
  output logic                          DDone,
  output logic                          Busy
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'(3);
  state_t state;
  logic owner, wr, last_d, lat_zero, grant, grant_d;
  logic [ADDR_W-1:0] base, grant_base;
  logic [DATA_W-1:0] wdata;
  logic [BW-1:0] beat;
  // D normally wins; lastD hands the next tie to I so it cannot starve
  assign grant = state == IDLE && (IReq || DReq);
  assign grant_d = DReq && !(IReq && last_d);
  assign grant_base = grant_d ? (DWrite ? DAddr & ~WORD_MASK : DAddr & ~LINE_MASK) : IAddr & ~LINE_MASK;
  mem_lat_counter #(.W(CW)) u_lat (
    .clk(CLK),
    .rst_n(CLR),
    .load(grant),
    .dec(state == WAIT && !lat_zero),
    .load_val(CW'(MEM_LAT - 1)),
    .zero(lat_zero)
  );
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state <= IDLE;
      owner <= OWN_I;
      wr <= 1'b0;
      last_d <= 1'b0;
      base <= '0;
      wdata <= '0;
      beat <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state <= WAIT;
          owner <= grant_d;
          wr <= grant_d && DWrite;
          base <= grant_base;
          wdata <= DWData;
        end
        WAIT: if (lat_zero) begin
          state <= wr ? WRITE : XFER;
          beat <= '0;
        end
        XFER: begin
          beat <= beat + 1'b1;
          if (beat == BW'(LINE_WORDS - 1)) state <= DONE;
        end
        WRITE: state <= DONE;
        DONE: begin
          last_d <= owner == OWN_D;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  assign MemAddr = (state == WAIT || state == WRITE) ? base : state == XFER ? base + (ADDR_W'(beat) << 2) : '0;
  assign MemWE = state == WRITE;
  assign MemWData = MemWE ? wdata : '0;
  assign FillValid = state == XFER;
  assign FillToD = owner;
  assign FillWord = beat;
  assign FillData = MemRData;
  assign IDone = state == DONE && owner == OWN_I;
  assign DDone = state == DONE && owner == OWN_D;
  assign Busy = state != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a timing-rule reference model
module tb_mem_arbiter;
  localparam int ML = 5;
  localparam int LW = 4;
  logic clk = 1'b0;
  logic clr, i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata, mem_addr, mem_wdata, mem_rdata, fill_data;
  logic mem_we, fill_valid, fill_to_d, i_done, d_done, busy;
  logic [1:0] fill_word;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign mem_rdata = mem(mem_addr);
  mem_arbiter #(.MEM_LAT(ML), .LINE_WORDS(LW), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(clk), .CLR(clr), .IReq(i_req), .IAddr(i_addr), .DReq(d_req), .DWrite(d_write),
    .DAddr(d_addr), .DWData(d_wdata), .MemAddr(mem_addr), .MemWE(mem_we), .MemWData(mem_wdata),
    .MemRData(mem_rdata), .FillValid(fill_valid), .FillToD(fill_to_d), .FillWord(fill_word),
    .FillData(fill_data), .IDone(i_done), .DDone(d_done), .Busy(busy)
  );
  // Reference: a transaction granted in cycle t0 owns cycles t0+1 .. t0+done_len
  int cyc = 0;
  int t0 = 0;
  logic m_busy = 1'b0, m_own = 1'b0, m_wr = 1'b0, m_last_d = 1'b0;
  logic [31:0] m_base = 0, m_data = 0;
  wire g_d = d_req && !(i_req && m_last_d);
  always @(posedge clk or negedge clr)
    if (!clr) begin
      m_busy <= 1'b0;
      m_last_d <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_busy) begin
        if (cyc - t0 == (m_wr ? ML + 2 : ML + LW + 1)) begin
          m_busy <= 1'b0;
          m_last_d <= m_own;
        end
      end else if (i_req || d_req) begin
        m_busy <= 1'b1;
        t0 <= cyc;
        m_own <= g_d;
        m_wr <= g_d && d_write;
        m_base <= g_d ? (d_write ? {d_addr[31:2], 2'b00} : {d_addr[31:4], 4'h0}) : {i_addr[31:4], 4'h0};
        m_data <= d_wdata;
      end
    end
  int rel;
  logic e_we, e_fv, e_idone, e_ddone;
  logic [31:0] e_addr, e_wdata;
  logic [1:0] e_word;
  always_comb begin
    rel = cyc - t0;
    e_we = 1'b0;
    e_fv = 1'b0;
    e_idone = 1'b0;
    e_ddone = 1'b0;
    e_addr = 32'h0;
    e_wdata = 32'h0;
    e_word = 2'd0;
    if (m_busy) begin
      if (rel <= ML) e_addr = m_base;
      if (!m_wr && rel > ML && rel <= ML + LW) begin
        e_fv = 1'b1;
        e_word = 2'(rel - ML - 1);
        e_addr = m_base + 32'(4 * (rel - ML - 1));
      end
      if (m_wr && rel == ML + 1) begin
        e_we = 1'b1;
        e_addr = m_base;
        e_wdata = m_data;
      end
      if (rel == (m_wr ? ML + 2 : ML + LW + 1)) begin
        e_idone = !m_own;
        e_ddone = m_own;
      end
    end
  end
  task automatic settle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_write = 1'b0;
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL settle: busy got %b want 0 within 40 cycles", busy);
    end
    @(negedge clk);
  endtask
  task automatic test_reset();
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, mem_we, fill_valid, i_done, d_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset flags: got %b want 00000", {busy, mem_we, fill_valid, i_done, d_done});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset data: addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    clr = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_ifill();
    logic [31:0] ea;
    @(negedge clk);
    i_addr = 32'h0000_104C;
    i_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      ea = k <= 5 ? 32'h1040 : k <= 9 ? 32'h1040 + 32'(4 * (k - 6)) : 32'h0;
      checks++;
      if (mem_addr !== ea) begin
        errors++;
        $display("FAIL ifill addr c%0d: got %h want %h", k, mem_addr, ea);
      end
      checks++;
      if (fill_valid !== (k >= 6 && k <= 9) || busy !== (k <= 10) || i_done !== (k == 10) || d_done !== 1'b0) begin
        errors++;
        $display("FAIL ifill flags c%0d: fv %b busy %b idone %b ddone %b", k, fill_valid, busy, i_done, d_done);
      end
      if (k >= 6 && k <= 9) begin
        checks++;
        if (fill_word !== 2'(k - 6) || fill_to_d !== 1'b0 || fill_data !== mem(ea)) begin
          errors++;
          $display("FAIL ifill beat c%0d: word %0d tod %b data %h want %0d 0 %h", k, fill_word, fill_to_d, fill_data, k - 6, mem(ea));
        end
      end
      if (i_done) i_req = 1'b0;
    end
    settle();
  endtask
  task automatic test_both();
    @(negedge clk);
    i_addr = 32'h0000_5014;
    d_addr = 32'h0000_6024;
    d_write = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      checks++;
      if (d_done !== (k == 10) || i_done !== (k == 21)) begin
        errors++;
        $display("FAIL both done c%0d: ddone %b idone %b", k, d_done, i_done);
      end
      checks++;
      if (fill_valid !== ((k >= 6 && k <= 9) || (k >= 17 && k <= 20))) begin
        errors++;
        $display("FAIL both fv c%0d: got %b", k, fill_valid);
      end
      if (fill_valid) begin
        checks++;
        if (fill_to_d !== (k <= 9) || mem_addr !== (k <= 9 ? 32'h6020 + 32'(4 * (k - 6)) : 32'h5010 + 32'(4 * (k - 17)))) begin
          errors++;
          $display("FAIL both beat c%0d: tod %b addr %h", k, fill_to_d, mem_addr);
        end
      end
      if (d_done) d_req = 1'b0;
      if (i_done) i_req = 1'b0;
    end
    settle();
  endtask
  task automatic test_alternate();
    int n_done = 0;
    int when_done[3];
    logic who[3];
    @(negedge clk);
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    d_write = 1'b0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int k = 1; k <= 60 && n_done < 3; k++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        when_done[n_done] = k;
        who[n_done] = d_done;
        n_done++;
      end
      if (i_done) i_req = 1'b0;
      if (n_done == 3) d_req = 1'b0;
    end
    checks++;
    if (n_done !== 3) begin
      errors++;
      $display("FAIL alternate count: got %0d dones want 3", n_done);
    end else begin
      checks++;
      if ({who[0], who[1], who[2]} !== 3'b101) begin
        errors++;
        $display("FAIL alternate order: got %b want 101 (D,I,D)", {who[0], who[1], who[2]});
      end
      checks++;
      if (when_done[0] != 10 || when_done[1] != 21 || when_done[2] != 32) begin
        errors++;
        $display("FAIL alternate timing: got %0d %0d %0d want 10 21 32", when_done[0], when_done[1], when_done[2]);
      end
    end
    settle();
  endtask
  task automatic test_dwrite();
    @(negedge clk);
    d_addr = 32'h0000_2008;
    d_wdata = 32'hDEAD_BEEF;
    d_write = 1'b1;
    d_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (mem_we !== (k == 6) || fill_valid !== 1'b0 || d_done !== (k == 7) || busy !== (k <= 7)) begin
        errors++;
        $display("FAIL dwrite flags c%0d: we %b fv %b ddone %b busy %b", k, mem_we, fill_valid, d_done, busy);
      end
      checks++;
      if (mem_addr !== (k <= 6 ? 32'h2008 : 32'h0) || mem_wdata !== (k == 6 ? 32'hDEAD_BEEF : 32'h0)) begin
        errors++;
        $display("FAIL dwrite data c%0d: addr %h wdata %h", k, mem_addr, mem_wdata);
      end
      if (d_done) d_req = 1'b0;
    end
    settle();
  endtask
  task automatic test_clr();
    @(negedge clk);
    i_addr = 32'h0000_7000;
    i_req = 1'b1;
    for (int k = 1; k <= 7; k++) @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if ({fill_valid, busy, i_done, mem_we} !== 4'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL clr abort: fv %b busy %b idone %b we %b addr %h", fill_valid, busy, i_done, mem_we, mem_addr);
    end
    @(negedge clk);
    clr = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (fill_valid !== (k >= 6 && k <= 9) || i_done !== (k == 10)) begin
        errors++;
        $display("FAIL clr regrant c%0d: fv %b idone %b", k, fill_valid, i_done);
      end
      if (i_done) i_req = 1'b0;
    end
    settle();
  endtask
  task automatic test_addr_change();
    @(negedge clk);
    d_addr = 32'h0000_2000;
    d_write = 1'b0;
    d_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 9) begin
        checks++;
        if (!fill_valid || mem_addr !== 32'h2000 + 32'(4 * (k - 6)) || fill_to_d !== 1'b1 || fill_data !== mem(mem_addr)) begin
          errors++;
          $display("FAIL addrchg beat c%0d: fv %b addr %h tod %b", k, fill_valid, mem_addr, fill_to_d);
        end
      end
      if (k == 3) d_addr = 32'h0000_3000;
      if (d_done) d_req = 1'b0;
    end
    settle();
  endtask
  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, mem_we, fill_valid, i_done, d_done} !== {m_busy, e_we, e_fv, e_idone, e_ddone}) begin
        errors++;
        $display("FAIL rand flags t%0d: got %b want %b", k, {busy, mem_we, fill_valid, i_done, d_done}, {m_busy, e_we, e_fv, e_idone, e_ddone});
      end
      checks++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand mem t%0d: addr %h wdata %h want %h %h", k, mem_addr, mem_wdata, e_addr, e_wdata);
      end
      if (e_fv) begin
        checks++;
        if (fill_word !== e_word || fill_to_d !== m_own || fill_data !== mem(e_addr)) begin
          errors++;
          $display("FAIL rand beat t%0d: word %0d tod %b data %h want %0d %b %h", k, fill_word, fill_to_d, fill_data, e_word, m_own, mem(e_addr));
        end
      end
      if (i_done) i_req = 1'b0;
      else if (!i_req && $urandom_range(0, 3) == 0) i_req = 1'b1;
      if (d_done) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1'b1;
        d_write = 1'($urandom_range(0, 1));
      end
      i_addr = $urandom;
      d_addr = $urandom;
      d_wdata = $urandom;
    end
    settle();
  endtask
  initial begin
    clr = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_write = 1'b0;
    i_addr = 32'h0;
    d_addr = 32'h0;
    d_wdata = 32'h0;
    test_reset();
    test_ifill();
    test_both();
    test_alternate();
    test_dwrite();
    test_clr();
    test_addr_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
